nibbler_core: RTL and testbench
===============================

Name: nibbler_core

Overview:
- Parametrised successor to the fixed 4-bit Nibbler accumulator processor.
- Data width, port count and call depth are parameters.
- Adds a ready/valid handshake on input ports, per-port output strobes, CALL/RET on a hardware LIFO, HALT, and an error state.
- Sits under the board level. Program memory is external, combinational-read ROM.

Parameters:
DW, 4, data/accumulator width (>=4)
AW, 12, program address width
NPORT, 3, number of input ports and number of output ports (1..16)
STACK_DEPTH, 4, CALL/RET return-address entries (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
prog_addr  out  AW  program counter to ROM
prog_data  in  4+AW  instruction; {opcode[3:0], operand[AW-1:0]}; valid combinationally for prog_addr
in_data  in  NPORT*DW  input port p at bits [p*DW +: DW]
in_valid  in  NPORT  input port p has data
in_ready  out  NPORT  one-cycle accept strobe per port
out_data  out  NPORT*DW  registered output ports
out_valid  out  NPORT  one-cycle strobe when port p is written
acc  out  DW  accumulator
c_flag  out  1  carry flag
z_flag  out  1  zero flag
halted  out  1  core stopped (HALT or error)
err  out  1  stack overflow/underflow occurred

Behaviour:
- Reset (asynchronous, active-low):
  - pc=0, acc=0, C=0, Z=0, all out_data=0, out_valid=0, in_ready=0, halted=0, err=0, stack empty, state=FETCH.
  - Reset asserted mid-instruction or mid-wait aborts it immediately; no partial writes survive.
- States:
  - FETCH: latch prog_data into IR; pc<=pc+1 (wraps 2^AW-1 -> 0); go EXEC.
  - EXEC: execute IR; normally go FETCH.
  - WAIT_IN: IN stalled on in_valid.
  - HALT: terminal until reset.
- Timing: every non-stalling instruction takes exactly 2 cycles; no pipelining.
- imm = operand[DW-1:0]; port index p = operand[3:0]; target = operand[AW-1:0].
- Opcodes:
  - 0 NOP.
  - 1 LIT: acc=imm; Z updated, C unchanged.
  - 2 ADDI: {C,acc}=acc+imm (DW+1-bit sum); Z=(acc==0).
  - 3 NANDI: acc=~(acc&imm); Z updated, C unchanged.
  - 4 CMPI: flags only; C=(acc>=imm) unsigned; Z=(acc==imm); acc unchanged.
  - 5 IN p: if in_valid[p] is high in EXEC: acc=in_data[p], in_ready[p]=1 that cycle, Z updated. Otherwise go WAIT_IN, hold there; in the first cycle in_valid[p]=1, load acc, assert in_ready[p], go FETCH.
  - 6 OUT p: out_data[p]<=acc; out_valid[p]=1 on the following cycle only, for exactly one cycle.
  - 7 JMP, 8 JC, 9 JNC, 10 JZ, 11 JNZ: pc<=target when the condition holds; otherwise pc keeps its FETCH-incremented value.
  - 12 CALL: push pc (already incremented) and set pc<=target. If the stack is full: set err=1, go HALT, do not push, pc unchanged.
  - 13 RET: pop into pc. If the stack is empty: err=1, go HALT.
  - 14 HALT: go HALT, halted=1.
  - 15: reserved, executes as NOP.
- Out-of-range port (p>=NPORT): IN loads 0, updates Z, never stalls, asserts no in_ready. OUT is ignored.
- At most one in_ready bit and one out_valid bit high in any cycle.
- in_valid on ports not currently addressed is ignored.
- In HALT: outputs hold, prog_addr holds, in_ready=0, out_valid=0.

Decomposition:
- Package nibbler_pkg:
  - opcode enum (OP_NOP..OP_RSVD, 4-bit).
  - state enum (FETCH, EXEC, WAIT_IN, HALT).
  - Field localparams: OPC_LSB=AW, PORT_W=4.
- Sub-module nibbler_stack:
  - Parameters DEPTH, W=AW.
  - Ports: push, pop, din, dout, full, empty; same clk and reset.
  - Simultaneous push and pop never requested by the core; the assertion bench checks this.

Test Plan:
- Reset/arith: LIT 9; ADDI 8 (DW=4) -> acc=1, C=1, Z=0; then NANDI 15 -> acc=14; ADDI 2 -> acc=0, C=1, Z=1.
- Branch: LIT 5; CMPI 5; JZ 0x020 -> prog_addr=0x020 on the next FETCH. CMPI 6; JC taken=no -> pc sequential.
- IN handshake: IN 1 with in_valid[1]=0 for 5 cycles, then in_data[1]=4, in_valid[1]=1 -> core stays in WAIT_IN 5 cycles; acc=4; in_ready[1] high exactly one cycle coincident with valid.
- OUT: LIT 6; OUT 2 -> out_data[2]=6, out_valid=3'b100 for one cycle; out_data[0..1] unchanged. OUT 7 (p>=NPORT) -> no strobe.
- Stack: nested CALLs to depth STACK_DEPTH then RETs -> return to correct addresses. One extra CALL -> err=1, halted=1, pc frozen. RET on empty after reset -> err=1.
- Async reset: drop reset low during WAIT_IN -> all outputs 0 within the same cycle; after release, prog_addr=0 and fetch restarts.

Source files
------------

// File: rtl/nibbler_pkg.sv
// Shared types for the parametrised Nibbler accumulator core:
// opcode and FSM state encodings plus instruction field positions.
package nibbler_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_LIT   = 4'd1,
    OP_ADDI  = 4'd2,
    OP_NANDI = 4'd3,
    OP_CMPI  = 4'd4,
    OP_IN    = 4'd5,
    OP_OUT   = 4'd6,
    OP_JMP   = 4'd7,
    OP_JC    = 4'd8,
    OP_JNC   = 4'd9,
    OP_JZ    = 4'd10,
    OP_JNZ   = 4'd11,
    OP_CALL  = 4'd12,
    OP_RET   = 4'd13,
    OP_HALT  = 4'd14,
    OP_RSVD  = 4'd15
  } opcode_t;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    EXEC    = 2'd1,
    WAIT_IN = 2'd2,
    HALT    = 2'd3
  } state_t;

  // Opcode sits directly above the operand; this is its LSB for the default AW.
  localparam int OPC_LSB = 12;
  localparam int PORT_W  = 4;

endpackage

// File: rtl/nibbler_stack.sv
// Return-address LIFO for CALL/RET. dout shows the top entry; the core
// guards push with full and pop with empty, and never requests both at once.
module nibbler_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int ND = 1 << CW;

  logic [W-1:0]  mem [ND];
  logic [CW-1:0] count;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[count - CW'(1)];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (push) begin
      count <= count + CW'(1);
    end else if (pop) begin
      count <= count - CW'(1);
    end
  end

  // Storage is not reset: entries above count are never read.
  always_ff @(posedge clk) begin
    if (push) mem[count] <= din;
  end

  push_pop_exclusive: assert property (@(posedge clk) disable iff (!reset) !(push && pop));

endmodule

// File: rtl/nibbler_core.sv
// Parametrised Nibbler accumulator core: two-cycle FETCH/EXEC machine with
// handshaked input ports, strobed output ports, CALL/RET stack and HALT/error.
module nibbler_core
  import nibbler_pkg::*;
#(
  parameter int DW          = 4,
  parameter int AW          = 12,
  parameter int NPORT       = 3,
  parameter int STACK_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  output logic [AW-1:0]       prog_addr,
  input  logic [4+AW-1:0]     prog_data,
  input  logic [NPORT*DW-1:0] in_data,
  input  logic [NPORT-1:0]    in_valid,
  output logic [NPORT-1:0]    in_ready,
  output logic [NPORT*DW-1:0] out_data,
  output logic [NPORT-1:0]    out_valid,
  output logic [DW-1:0]       acc,
  output logic                c_flag,
  output logic                z_flag,
  output logic                halted,
  output logic                err,
  output logic [1:0]          dbg_state
);

  state_t          state;
  logic [AW-1:0]   pc;
  logic [AW+3:0]   ir;
  opcode_t         opc;
  logic [AW-1:0]   target;
  logic [DW-1:0]   imm;
  logic [PORT_W-1:0] port;
  logic            port_ok, in_hit, in_ctx;
  logic [DW-1:0]   in_sel;
  logic [DW:0]     sum;
  logic            stk_push, stk_pop, stk_full, stk_empty;
  logic [AW-1:0]   stk_dout;

  assign opc       = opcode_t'(ir[AW +: 4]);
  assign target    = ir[AW-1:0];
  assign imm       = ir[DW-1:0];
  assign port      = ir[PORT_W-1:0];
  assign prog_addr = pc;
  assign dbg_state = state;
  assign sum       = {1'b0, acc} + {1'b0, imm};

  always_comb begin
    port_ok = 1'b0;
    in_hit  = 1'b0;
    in_sel  = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (port == PORT_W'(i)) begin
        port_ok = 1'b1;
        in_hit  = in_valid[i];
        in_sel  = in_data[i*DW +: DW];
      end
    end
  end

  // Input handshake: a word transfers in the cycle where in_valid[p] and
  // in_ready[p] are both high; in_ready is only raised for the addressed port.
  assign in_ctx = ((state == EXEC) && (opc == OP_IN)) || (state == WAIT_IN);
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NPORT; i++) begin
      in_ready[i] = in_ctx && (port == PORT_W'(i)) && in_valid[i];
    end
  end

  assign stk_push = (state == EXEC) && (opc == OP_CALL) && !stk_full;
  assign stk_pop  = (state == EXEC) && (opc == OP_RET) && !stk_empty;

  nibbler_stack #(.DEPTH(STACK_DEPTH), .W(AW)) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (pc),
    .dout  (stk_dout),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FETCH;
      pc        <= '0;
      ir        <= '0;
      acc       <= '0;
      c_flag    <= 1'b0;
      z_flag    <= 1'b0;
      out_data  <= '0;
      out_valid <= '0;
      halted    <= 1'b0;
      err       <= 1'b0;
    end else begin
      out_valid <= '0;
      case (state)
        FETCH: begin
          ir    <= prog_data;
          pc    <= pc + AW'(1);
          state <= EXEC;
        end
        EXEC: begin
          state <= FETCH;
          case (opc)
            OP_LIT: begin
              acc    <= imm;
              z_flag <= (imm == '0);
            end
            OP_ADDI: begin
              {c_flag, acc} <= sum;
              z_flag        <= (sum[DW-1:0] == '0);
            end
            OP_NANDI: begin
              acc    <= ~(acc & imm);
              z_flag <= ((acc & imm) == '1);
            end
            OP_CMPI: begin
              c_flag <= (acc >= imm);
              z_flag <= (acc == imm);
            end
            OP_IN: begin
              // Unknown ports read as zero and never stall.
              if (!port_ok) begin
                acc    <= '0;
                z_flag <= 1'b1;
              end else if (in_hit) begin
                acc    <= in_sel;
                z_flag <= (in_sel == '0);
              end else begin
                state <= WAIT_IN;
              end
            end
            OP_OUT: begin
              for (int i = 0; i < NPORT; i++) begin
                if (port == PORT_W'(i)) begin
                  out_data[i*DW +: DW] <= acc;
                  out_valid[i]         <= 1'b1;
                end
              end
            end
            OP_JMP: pc <= target;
            OP_JC:  if (c_flag)  pc <= target;
            OP_JNC: if (!c_flag) pc <= target;
            OP_JZ:  if (z_flag)  pc <= target;
            OP_JNZ: if (!z_flag) pc <= target;
            OP_CALL: begin
              if (stk_full) begin
                err    <= 1'b1;
                halted <= 1'b1;
                state  <= HALT;
              end else begin
                pc <= target;
              end
            end
            OP_RET: begin
              if (stk_empty) begin
                err    <= 1'b1;
                halted <= 1'b1;
                state  <= HALT;
              end else begin
                pc <= stk_dout;
              end
            end
            OP_HALT: begin
              halted <= 1'b1;
              state  <= HALT;
            end
            default: ;
          endcase
        end
        WAIT_IN: begin
          if (in_hit) begin
            acc    <= in_sel;
            z_flag <= (in_sel == '0);
            state  <= FETCH;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibbler_core.sv
// Directed bench for nibbler_core: ROM-driven programs, a scoreboard of
// expected port events, and end-of-program architectural checks.
module tb_nibbler_core;
  import nibbler_pkg::*;

  localparam int DW = 4, AW = 12, NPORT = 3, SD = 4;
  localparam logic [3:0] K_OUT = 4'd1, K_IN = 4'd2;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0]       prog_addr;
  logic [4+AW-1:0]     prog_data;
  logic [NPORT*DW-1:0] in_data = '0;
  logic [NPORT-1:0]    in_valid = '0;
  logic [NPORT-1:0]    in_ready;
  logic [NPORT*DW-1:0] out_data;
  logic [NPORT-1:0]    out_valid;
  logic [DW-1:0]       acc;
  logic                c_flag, z_flag, halted, err;
  logic [1:0]          dbg_state;

  logic [15:0] rom [4096];
  assign prog_data = rom[prog_addr];

  nibbler_core #(.DW(DW), .AW(AW), .NPORT(NPORT), .STACK_DEPTH(SD)) dut (
    .clk(clk), .reset(reset), .prog_addr(prog_addr), .prog_data(prog_data),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .acc(acc),
    .c_flag(c_flag), .z_flag(z_flag), .halted(halted), .err(err),
    .dbg_state(dbg_state)
  );

  // scoreboard
  int n_chk = 0;
  int n_pass = 0;
  logic [11:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  function automatic logic [11:0] ev(input logic [3:0] kind, input logic [3:0] p, input logic [3:0] d);
    return {kind, p, d};
  endfunction

  task automatic pop_cmp(input string name, input logic [11:0] got);
    if (exp_q.size() == 0) begin
      n_chk++;
      $display("FAIL %s: got event 0x%0h required no event", name, got);
    end else begin
      chk(name, got, exp_q.pop_front());
    end
  endtask

  // monitor: every strobe on out_valid / in_ready must match the next expected event
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        if (out_valid != '0) begin
          chk("out_onehot", $countones(out_valid), 1);
          for (int i = 0; i < NPORT; i++)
            if (out_valid[i]) pop_cmp("out_event", ev(K_OUT, 4'(i), out_data[i*DW +: DW]));
        end
        if (in_ready != '0) begin
          chk("in_onehot", $countones(in_ready), 1);
          for (int i = 0; i < NPORT; i++)
            if (in_ready[i]) pop_cmp("in_event", ev(K_IN, 4'(i), in_data[i*DW +: DW]));
        end
      end
    end
  end

  // driver tasks
  function automatic logic [15:0] ins(input opcode_t op, input logic [11:0] opd);
    return {op, opd};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) rom[i] = ins(OP_NOP, 12'h000);
  endtask

  task automatic start_prog();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_halt(input string name, input int budget);
    int k = 0;
    while (!halted && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, {31'd0, halted}, 32'd1);
  endtask

  task automatic wait_state(input string name, input state_t st, input int budget);
    int k = 0;
    while (dbg_state != st && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, {30'd0, dbg_state}, {30'd0, st});
  endtask

  task automatic wait_fetch_at(input string name, input logic [11:0] a, input int budget);
    int k = 0;
    while (!(dbg_state == FETCH && prog_addr == a) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, {dbg_state, prog_addr}, {FETCH, a});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- A: reset state and arithmetic ----
    #1 reset = 1'b0;
    clear_rom();
    rom[0] = ins(OP_LIT, 12'd9);
    rom[1] = ins(OP_ADDI, 12'd8);
    rom[2] = ins(OP_OUT, 12'd0);
    rom[3] = ins(OP_JC, 12'd5);
    rom[4] = ins(OP_OUT, 12'd1);
    rom[5] = ins(OP_NANDI, 12'd15);
    rom[6] = ins(OP_OUT, 12'd1);
    rom[7] = ins(OP_ADDI, 12'd2);
    rom[8] = ins(OP_HALT, 12'd0);
    @(negedge clk);
    chk("rst_prog_addr", prog_addr, 12'h000);
    chk("rst_acc", acc, 4'h0);
    chk("rst_flags", {c_flag, z_flag, halted, err}, 4'b0000);
    chk("rst_ports", {out_data, out_valid, in_ready}, '0);
    chk("rst_state", dbg_state, FETCH);
    exp_q.push_back(ev(K_OUT, 4'd0, 4'd1));
    exp_q.push_back(ev(K_OUT, 4'd1, 4'd14));
    start_prog();
    wait_halt("a_halt", 100);
    chk("a_acc", acc, 4'd0);
    chk("a_cz", {c_flag, z_flag}, 2'b11);
    chk("a_err", err, 1'b0);
    chk("a_pc", prog_addr, 12'd9);
    chk("a_out_data", out_data, 12'h0E1);
    chk("a_queue", exp_q.size(), 0);

    // ---- B: compare and branches ----
    reset = 1'b0;
    clear_rom();
    rom[12'h000] = ins(OP_LIT, 12'd5);
    rom[12'h001] = ins(OP_CMPI, 12'd5);
    rom[12'h002] = ins(OP_JZ, 12'h020);
    rom[12'h003] = ins(OP_HALT, 12'd0);
    rom[12'h020] = ins(OP_CMPI, 12'd6);
    rom[12'h021] = ins(OP_JC, 12'h030);
    rom[12'h022] = ins(OP_JNC, 12'h024);
    rom[12'h023] = ins(OP_HALT, 12'd0);
    rom[12'h024] = ins(OP_OUT, 12'd2);
    rom[12'h025] = ins(OP_JNZ, 12'h028);
    rom[12'h026] = ins(OP_HALT, 12'd0);
    rom[12'h028] = ins(OP_LIT, 12'd0);
    rom[12'h029] = ins(OP_JNZ, 12'h030);
    rom[12'h02A] = ins(OP_JMP, 12'h040);
    rom[12'h030] = ins(OP_LIT, 12'd15);
    rom[12'h031] = ins(OP_HALT, 12'd0);
    rom[12'h040] = ins(OP_HALT, 12'd0);
    exp_q.push_back(ev(K_OUT, 4'd2, 4'd5));
    start_prog();
    wait_fetch_at("b_jz_target", 12'h020, 20);
    wait_halt("b_halt", 100);
    chk("b_acc", acc, 4'd0);
    chk("b_cz", {c_flag, z_flag}, 2'b01);
    chk("b_pc", prog_addr, 12'h041);
    chk("b_queue", exp_q.size(), 0);

    // ---- C: IN handshake, stall, out-of-range IN ----
    reset = 1'b0;
    clear_rom();
    rom[0] = ins(OP_IN, 12'd1);
    rom[1] = ins(OP_OUT, 12'd0);
    rom[2] = ins(OP_IN, 12'd7);
    rom[3] = ins(OP_HALT, 12'd0);
    in_data  = {4'hA, 4'h0, 4'h3};
    in_valid = 3'b101;
    exp_q.push_back(ev(K_IN, 4'd1, 4'd4));
    exp_q.push_back(ev(K_OUT, 4'd0, 4'd4));
    start_prog();
    wait_state("c_wait_in", WAIT_IN, 10);
    begin
      int bad = 0;
      repeat (5) begin
        @(negedge clk);
        if (dbg_state != WAIT_IN || in_ready != '0) bad++;
      end
      chk("c_stall", bad, 0);
    end
    @(posedge clk);
    #1;
    in_data[7:4] = 4'd4;
    in_valid[1]  = 1'b1;
    @(posedge clk);
    #1;
    in_valid[1] = 1'b0;
    wait_halt("c_halt", 50);
    chk("c_acc", acc, 4'd0);
    chk("c_z", z_flag, 1'b1);
    chk("c_pc", prog_addr, 12'd4);
    chk("c_queue", exp_q.size(), 0);
    in_valid = '0;

    // ---- D: OUT strobes and ignored out-of-range OUT ----
    reset = 1'b0;
    clear_rom();
    rom[0] = ins(OP_LIT, 12'd3);
    rom[1] = ins(OP_OUT, 12'd0);
    rom[2] = ins(OP_LIT, 12'd6);
    rom[3] = ins(OP_OUT, 12'd2);
    rom[4] = ins(OP_OUT, 12'd7);
    rom[5] = ins(OP_LIT, 12'd9);
    rom[6] = ins(OP_HALT, 12'd0);
    exp_q.push_back(ev(K_OUT, 4'd0, 4'd3));
    exp_q.push_back(ev(K_OUT, 4'd2, 4'd6));
    start_prog();
    wait_halt("d_halt", 50);
    chk("d_out_data", out_data, 12'h603);
    chk("d_acc_pc", {acc, prog_addr}, {4'd9, 12'd7});
    chk("d_queue", exp_q.size(), 0);

    // ---- E: nested CALL/RET to full depth ----
    reset = 1'b0;
    clear_rom();
    rom[12'h000] = ins(OP_CALL, 12'h100);
    rom[12'h001] = ins(OP_LIT, 12'd1);
    rom[12'h002] = ins(OP_OUT, 12'd0);
    rom[12'h003] = ins(OP_HALT, 12'd0);
    for (int l = 1; l <= 3; l++) begin
      rom[12'(l * 256) + 12'd0] = ins(OP_CALL, 12'((l + 1) * 256));
      rom[12'(l * 256) + 12'd1] = ins(OP_LIT, 12'(l + 1));
      rom[12'(l * 256) + 12'd2] = ins(OP_OUT, 12'd0);
      rom[12'(l * 256) + 12'd3] = ins(OP_RET, 12'd0);
    end
    rom[12'h400] = ins(OP_LIT, 12'd5);
    rom[12'h401] = ins(OP_OUT, 12'd0);
    rom[12'h402] = ins(OP_RET, 12'd0);
    for (int d = 5; d >= 1; d--) exp_q.push_back(ev(K_OUT, 4'd0, 4'(d)));
    start_prog();
    wait_halt("e_halt", 200);
    chk("e_err", err, 1'b0);
    chk("e_pc", prog_addr, 12'd4);
    chk("e_queue", exp_q.size(), 0);

    // ---- F: CALL on a full stack ----
    reset = 1'b0;
    clear_rom();
    for (int i = 0; i < 4; i++) rom[i] = ins(OP_CALL, 12'(i + 1));
    rom[4]     = ins(OP_CALL, 12'h010);
    rom[12'h010] = ins(OP_LIT, 12'd15);
    rom[12'h011] = ins(OP_OUT, 12'd0);
    start_prog();
    wait_halt("f_halt", 50);
    chk("f_err", err, 1'b1);
    chk("f_pc", prog_addr, 12'd5);
    repeat (10) @(negedge clk);
    chk("f_pc_frozen", {dbg_state, prog_addr}, {HALT, 12'd5});
    chk("f_queue", exp_q.size(), 0);

    // ---- G: RET on an empty stack ----
    reset = 1'b0;
    clear_rom();
    rom[0] = ins(OP_RET, 12'd0);
    start_prog();
    wait_halt("g_halt", 20);
    chk("g_err_pc", {err, prog_addr}, {1'b1, 12'd1});

    // ---- H: asynchronous reset during WAIT_IN ----
    reset = 1'b0;
    clear_rom();
    rom[0] = ins(OP_LIT, 12'd7);
    rom[1] = ins(OP_OUT, 12'd1);
    rom[2] = ins(OP_IN, 12'd0);
    rom[3] = ins(OP_HALT, 12'd0);
    in_data = '0;
    exp_q.push_back(ev(K_OUT, 4'd1, 4'd7));
    start_prog();
    wait_state("h_wait_in", WAIT_IN, 20);
    chk("h_queue_pre", exp_q.size(), 0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("h_rst_acc_out", {acc, out_data, out_valid, in_ready}, '0);
    chk("h_rst_pc_state", {dbg_state, prog_addr}, {FETCH, 12'd0});
    chk("h_rst_flags", {c_flag, z_flag, halted, err}, 4'b0000);
    exp_q.push_back(ev(K_OUT, 4'd1, 4'd7));
    exp_q.push_back(ev(K_IN, 4'd0, 4'd2));
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("h_restart", {dbg_state, prog_addr}, {FETCH, 12'd0});
    wait_state("h_wait_in2", WAIT_IN, 20);
    @(posedge clk);
    #1;
    in_data[3:0] = 4'd2;
    in_valid[0]  = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    wait_halt("h_halt", 20);
    chk("h_acc_pc", {acc, prog_addr}, {4'd2, 12'd4});
    chk("h_queue", exp_q.size(), 0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
